serial_subtractor: RTL and testbench

Bit-serial unsigned subtractor computing `a - b - bin` one bit per clock, LSB first, with a start/done handshake. It is the inverse-direction counterpart of the team's combinational ripple adder: it uses a single 1-bit full-subtractor cell, iterated under a small FSM. It sits beside the adder in the arithmetic exercises and is compared against it in system-level checks (`a == (a - b) + b`).

---
 rtl/arith_pkg.sv | 15 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 101 ++++++++++
 tb/tb_serial_subtractor.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-exercise constants: FSM state codes and the default operand width.
package arith_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int unsigned ARITH_W = 4;

  // Bit-counter width; a single-bit operand still needs a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// Combinational 1-bit full-subtractor cell: d = x - y - bi, with borrow-out bo.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b - bin, LSB first, one bit per clock,
// with a start/done handshake and results held until the next accepted start.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = ARITH_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned CW = cnt_width(WIDTH);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic             br;
  logic             d;
  logic             bo;
  logic             last;

  full_subtractor u_cell (
    .x  (sa[0]),
    .y  (sb[0]),
    .bi (br),
    .d  (d),
    .bo (bo)
  );

  // Result bits enter at the MSB so that after WIDTH shifts bit 0 sits at LSB.
  always_comb begin
    sr_next            = sr >> 1;
    sr_next[WIDTH-1]   = d;
  end

  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      cnt   <= '0;
      sa    <= '0;
      sb    <= '0;
      sr    <= '0;
      br    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            sa    <= a;
            sb    <= b;
            br    <= bin;
            cnt   <= '0;
            sr    <= '0;
          end
        end
        RUN: begin
          sa <= sa >> 1;
          sb <= sb >> 1;
          br <= bo;
          sr <= sr_next;
          if (last) begin
            state <= DONE;
            done  <= 1'b1;
            diff  <= sr_next;
            bout  <= bo;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at WIDTH = 4.
module tb_serial_subtractor;
  import arith_pkg::*;

  localparam int unsigned W = ARITH_W;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  int total;
  int bad;
  int cyc;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    int dones;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    tick(); tick();
    start = 1'b1; a = 4'd7; b = 4'd3;
    tick();
    total++;
    if ({busy, done, diff, bout} !== 7'd0) begin
      bad++;
      $display("FAIL reset_outputs: busy=%b done=%b diff=%b bout=%b, required all 0", busy, done, diff, bout);
    end
    start = 1'b0;
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    total++;
    if (dones !== 0) begin
      bad++;
      $display("FAIL reset_idle: %0d cycles with done/busy, required 0", dones);
    end
  endtask

  task automatic test_basic();
    a = 4'd7; b = 4'd3; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; a = 4'd0; b = 4'd0;
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL basic_accept: busy=%b done=%b, required busy=1 done=0", busy, done);
    end
    for (int i = 1; i < 4; i++) begin
      tick();
      total++;
      if (done !== 1'b0) begin
        bad++;
        $display("FAIL basic_early_done: edge %0d done=%b, required 0", i, done);
      end
    end
    tick();
    total++;
    if (done !== 1'b1 || busy !== 1'b1 || diff !== 4'b0100 || bout !== 1'b0) begin
      bad++;
      $display("FAIL basic_result: done=%b busy=%b diff=%b bout=%b, required 1 1 0100 0", done, busy, diff, bout);
    end
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || diff !== 4'b0100) begin
      bad++;
      $display("FAIL basic_idle: done=%b busy=%b diff=%b, required 0 0 0100", done, busy, diff);
    end
  endtask

  task automatic test_borrow();
    logic [W-1:0] ta [3];
    logic [W-1:0] tb [3];
    logic         tbin [3];
    logic [W-1:0] td [3];
    logic         tbo [3];
    int n;
    ta[0] = 4'd3;  tb[0] = 4'd7;  tbin[0] = 1'b0; td[0] = 4'b1100; tbo[0] = 1'b1;
    ta[1] = 4'd0;  tb[1] = 4'd0;  tbin[1] = 1'b1; td[1] = 4'b1111; tbo[1] = 1'b1;
    ta[2] = 4'd15; tb[2] = 4'd11; tbin[2] = 1'b0; td[2] = 4'b0100; tbo[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a = ta[k]; b = tb[k]; bin = tbin[k]; start = 1'b1;
      tick();
      start = 1'b0; bin = 1'b0;
      n = 0;
      while (done !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      total++;
      if (n !== 4 || diff !== td[k] || bout !== tbo[k]) begin
        bad++;
        $display("FAIL borrow_case%0d: edges=%0d diff=%b bout=%b, required edges=4 diff=%b bout=%b",
                 k, n, diff, bout, td[k], tbo[k]);
      end
      tick();
    end
  endtask

  task automatic test_busy_reject();
    int dones;
    a = 4'd9; b = 4'd2; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    // Re-request across the remaining RUN edges and the DONE edge.
    start = 1'b1; a = 4'd1; b = 4'd1;
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    total++;
    if (dones !== 1 || diff !== 4'd7 || bout !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL busy_reject: dones=%0d diff=%0d bout=%b busy=%b, required 1 7 0 0", dones, diff, bout, busy);
    end
  endtask

  task automatic test_reset_midop();
    int dones;
    a = 4'd12; b = 4'd1; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    total++;
    if ({busy, done, diff, bout} !== 7'd0) begin
      bad++;
      $display("FAIL midop_reset: busy=%b done=%b diff=%b bout=%b, required all 0", busy, done, diff, bout);
    end
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    total++;
    if (dones !== 0) begin
      bad++;
      $display("FAIL midop_no_done: %0d active cycles after reset, required 0", dones);
    end
    a = 4'd5; b = 4'd5; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    total++;
    if (done !== 1'b1 || diff !== 4'd0 || bout !== 1'b0) begin
      bad++;
      $display("FAIL midop_rerun: done=%b diff=%b bout=%b, required 1 0000 0", done, diff, bout);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [W:0] exp;
    logic [W:0] nxt;
    int n;
    int last_done;
    nxt = '0;
    exp = '0;
    last_done = 0;
    start = 1'b1;
    a = '0; b = '0; bin = 1'b0;
    for (int i = 0; i < 512; i++) begin
      exp = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
      tick();
      total++;
      if (busy !== 1'b1) begin
        bad++;
        $display("FAIL b2b_accept%0d: busy=%b, required 1", i, busy);
      end
      if (i < 511) begin
        nxt = (W+1)'(i + 1);
        {bin, b, a} = {nxt[0], 4'((i + 1) >> 1), 4'((i + 1) >> 5)};
      end else begin
        start = 1'b0;
      end
      n = 0;
      while (done !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      total++;
      if (n !== 4 || diff !== exp[W-1:0] || bout !== exp[W]) begin
        bad++;
        $display("FAIL b2b_result%0d: edges=%0d diff=%b bout=%b, required edges=4 diff=%b bout=%b",
                 i, n, diff, bout, exp[W-1:0], exp[W]);
      end
      if (i > 0) begin
        total++;
        if (cyc - last_done !== 6) begin
          bad++;
          $display("FAIL b2b_spacing%0d: %0d cycles, required 6", i, cyc - last_done);
        end
      end
      last_done = cyc;
      tick();
    end
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_end_idle: busy=%b, required 0", busy);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    cyc = 0;
    test_reset();
    test_basic();
    test_borrow();
    test_busy_reject();
    test_reset_midop();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
